// File: rtl/bcd_pkg.sv
// bcd_pkg: shared constants, types and the BCD-to-7-segment decode function
// for the bcd_seg_scanner display path.
//   BCD_W      : width of one BCD digit
//   seg_t      : 7-bit segment vector {g,f,e,d,c,b,a}, active-high
//   SEG_*      : segment patterns for 0..9 and the dash used for invalid codes
//   seg_decode : nibble -> seg_t; codes 10..15 map to SEG_DASH
package bcd_pkg;

    localparam int BCD_W = 4;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_0    = 7'h3F;
    localparam seg_t SEG_1    = 7'h06;
    localparam seg_t SEG_2    = 7'h5B;
    localparam seg_t SEG_3    = 7'h4F;
    localparam seg_t SEG_4    = 7'h66;
    localparam seg_t SEG_5    = 7'h6D;
    localparam seg_t SEG_6    = 7'h7D;
    localparam seg_t SEG_7    = 7'h07;
    localparam seg_t SEG_8    = 7'h7F;
    localparam seg_t SEG_9    = 7'h6F;
    localparam seg_t SEG_DASH = 7'h40;

    function automatic seg_t seg_decode(input logic [BCD_W-1:0] digit);
        seg_t seg;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/bcd_seg_scanner_if.sv
// bcd_seg_scanner_if: bundles the digit input and display outputs of the
// scanner.
//   digits_in   : packed BCD digits, nibble [3:0] is digit 0
//   seg_out     : registered segments {g,f,e,d,c,b,a}, active-high
//   an_out      : registered one-hot digit enable, bit i = digit i
//   frame_start : one-cycle pulse when a new snapshot is captured
//   err_out     : sticky invalid-BCD flag
// Modports: master (digit source / display observer), slave (the scanner).
interface bcd_seg_scanner_if
    import bcd_pkg::*;
#(
    parameter int N_DIGITS = 4
);

    logic [BCD_W*N_DIGITS-1:0] digits_in;
    seg_t                      seg_out;
    logic [N_DIGITS-1:0]       an_out;
    logic                      frame_start;
    logic                      err_out;

    modport master (
        output digits_in,
        input  seg_out,
        input  an_out,
        input  frame_start,
        input  err_out
    );

    modport slave (
        input  digits_in,
        output seg_out,
        output an_out,
        output frame_start,
        output err_out
    );

endinterface

// File: rtl/bcd_to_seg.sv
// bcd_to_seg: purely combinational BCD nibble to 7-segment decoder.
//   digit : 4-bit BCD code
//   seg   : segments {g,f,e,d,c,b,a}; invalid codes give a dash
module bcd_to_seg
    import bcd_pkg::*;
(
    input  logic [BCD_W-1:0] digit,
    output seg_t             seg
);

    assign seg = seg_decode(digit);

endmodule

// File: rtl/bcd_seg_scanner.sv
// bcd_seg_scanner: time-multiplexed 7-segment driver for N packed BCD digits.
// All digits are snapshotted once per frame so a digit never changes while a
// frame is being scanned; each digit is shown for PRESCALE cycles.
//   clk      : system clock, rising edge
//   rst_asyn : asynchronous active-high reset
//   bus      : bcd_seg_scanner_if.slave (digits_in, seg_out, an_out,
//              frame_start, err_out)
// Optional build macro BCD_SEG_LZB_EN enables leading-zero blanking: digit i>0
// is blanked while it and every more-significant snapshot digit are zero.
module bcd_seg_scanner
    import bcd_pkg::*;
#(
    parameter int N_DIGITS = 4,
    parameter int PRESCALE = 4
) (
    input logic               clk,
    input logic               rst_asyn,
    bcd_seg_scanner_if.slave  bus
);

    localparam int PW = $clog2(PRESCALE);
    localparam int DW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    logic [PW-1:0]             pres_cnt_q, pres_cnt_d;
    logic [DW-1:0]             dig_idx_q, dig_idx_d;
    logic [BCD_W*N_DIGITS-1:0] snapshot_q, snapshot_d;
    logic                      loaded_q, loaded_d;
    seg_t                      seg_q, seg_d;
    logic [N_DIGITS-1:0]       an_q, an_d;
    logic                      frame_q, frame_d;
    logic                      err_q, err_d;

    logic                      tick;
    logic                      last_dig;
    logic                      in_invalid;
    logic [BCD_W-1:0]          cur_digit;
    seg_t                      cur_seg;
    logic [N_DIGITS-1:0]       an_sel;
    logic                      cur_blank;

    assign tick      = (pres_cnt_q == PW'(PRESCALE - 1));
    assign last_dig  = (dig_idx_q == DW'(N_DIGITS - 1));
    assign cur_digit = snapshot_q[BCD_W*int'(dig_idx_q) +: BCD_W];

    // Any nibble of the incoming word above 9 marks the capture as invalid.
    always_comb begin
        in_invalid = 1'b0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (bus.digits_in[BCD_W*i +: BCD_W] > 4'd9) begin
                in_invalid = 1'b1;
            end
        end
    end

    always_comb begin
        an_sel            = '0;
        an_sel[dig_idx_q] = 1'b1;
    end

`ifdef BCD_SEG_LZB_EN
    logic [N_DIGITS-1:0] blank;

    // Walk from the most-significant digit down; blanking stops at the first
    // non-zero digit. Digit 0 is never blanked.
    always_comb begin
        logic zero_run;
        blank    = '0;
        zero_run = 1'b1;
        for (int i = N_DIGITS - 1; i >= 1; i--) begin
            zero_run = zero_run & (snapshot_q[BCD_W*i +: BCD_W] == '0);
            blank[i] = zero_run;
        end
    end

    assign cur_blank = blank[dig_idx_q];
`else
    assign cur_blank = 1'b0;
`endif

    bcd_to_seg u_bcd_to_seg (
        .digit (cur_digit),
        .seg   (cur_seg)
    );

    always_comb begin
        pres_cnt_d = pres_cnt_q;
        dig_idx_d  = dig_idx_q;
        snapshot_d = snapshot_q;
        loaded_d   = 1'b1;
        seg_d      = seg_q;
        an_d       = an_q;
        frame_d    = 1'b0;
        err_d      = err_q;

        if (!loaded_q) begin
            // First edge after reset: capture only, display stays dark.
            snapshot_d = bus.digits_in;
            err_d      = err_q | in_invalid;
        end else begin
            pres_cnt_d = tick ? '0 : pres_cnt_q + 1'b1;
            if (tick) begin
                dig_idx_d = last_dig ? '0 : dig_idx_q + 1'b1;
            end
            if (tick && last_dig) begin
                snapshot_d = bus.digits_in;
                frame_d    = 1'b1;
                err_d      = err_q | in_invalid;
            end
            // Outputs register the current slot, giving a one-cycle lag.
            an_d  = cur_blank ? '0 : an_sel;
            seg_d = cur_blank ? '0 : cur_seg;
        end
    end

    always_ff @(posedge clk or posedge rst_asyn) begin
        if (rst_asyn) begin
            pres_cnt_q <= '0;
            dig_idx_q  <= '0;
            snapshot_q <= '0;
            loaded_q   <= 1'b0;
            seg_q      <= '0;
            an_q       <= '0;
            frame_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            pres_cnt_q <= pres_cnt_d;
            dig_idx_q  <= dig_idx_d;
            snapshot_q <= snapshot_d;
            loaded_q   <= loaded_d;
            seg_q      <= seg_d;
            an_q       <= an_d;
            frame_q    <= frame_d;
            err_q      <= err_d;
        end
    end

    assign bus.seg_out     = seg_q;
    assign bus.an_out      = an_q;
    assign bus.frame_start = frame_q;
    assign bus.err_out     = err_q;

endmodule
